// File: rtl/uart_pkg.sv
// Shared UART definitions: memory-map addresses used by the core's decode
// and the drain state encoding of the buffered transmitter.
package uart_pkg;

  localparam logic [31:0] UART_RW_ADDRESS     = 32'h0000_0400;
  localparam logic [31:0] UART_STATUS_ADDRESS = 32'h0000_0404;
  localparam logic [31:0] BAUD_MAX_ADDRESS    = 32'h0000_0408;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ARM,
    DRAIN
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with registered occupancy count and flush.
// The caller qualifies push/pop (no push when full without a pop, no pop when empty).
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Flush discards a same-cycle push and pop; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit front-end: core stores fill a FIFO and a drain FSM
// launches one byte at a time into the Uart, pacing on its busy flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          clr_overflow,
  input  logic          uart_busy,
  output logic [7:0]    uart_data,
  output logic          uart_write_enable,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          tx_active
);

  uart_tx_state_t state, state_next;
  logic           pop;
  logic           push;
  logic           drop;
  logic [7:0]     fifo_rd_data;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // alongside it. A flush swallows the push without flagging overflow.
  assign pop  = (state == IDLE) && !empty && !uart_busy && !flush;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop && !flush;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ARM skips the busy check: Uart raises busy one cycle after write_enable.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pop) state_next = SEND;
      SEND:    state_next = ARM;
      ARM:     state_next = DRAIN;
      DRAIN:   if (!uart_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      uart_data <= 8'h00;
    else if (pop) uart_data <= fifo_rd_data;
  end

  // A dropped push beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  assign uart_write_enable = (state == SEND);
  assign tx_active         = !empty || (state != IDLE);

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered transmit front-end between the core's memory-mapped store path and the `Uart` transmitter. A store to `UART_RW_ADDRESS` pushes one byte into a small FIFO instead of driving `Uart` directly. A drain state machine hands bytes to `Uart` one at a time, pacing itself on `Uart.busy`. Software only has to poll `full`, not `busy`, so bursts of up to `DEPTH` characters cost no stall.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `CW`, `$clog2(DEPTH)+1`: width of `count`; derived, never overridden.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  push request: core store to `UART_RW_ADDRESS`, already address-qualified.
- `wr_data`  in  8  byte to push (core `write_data[7:0]`).
- `flush`  in  1  discard all queued bytes; does not abort a byte already handed to `Uart`.
- `clr_overflow`  in  1  clears the `overflow` sticky flag.
- `uart_busy`  in  1  `Uart.busy`.
- `uart_data`  out  8  byte presented to `Uart.data`.
- `uart_write_enable`  out  1  one-cycle launch pulse to `Uart.write_enable`.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `count`  out  CW  occupied entries.
- `overflow`  out  1  sticky: a push was dropped.
- `tx_active`  out  1  FIFO non-empty or drain FSM not IDLE; replaces `busy` in the line-status bit.

## Operation
- Storage: circular buffer, `rd_ptr`/`wr_ptr` of `$clog2(DEPTH)` bits, wrap naturally at DEPTH. Registered `count` tracks occupancy.
- Push: accepted when `wr_en && (!full || pop)`. `pop` is the FIFO read in the same cycle. Accepted pushes write `mem[wr_ptr]` and increment `wr_ptr`.
- Dropped push: `wr_en && full && !pop`. No state change except `overflow <= 1`.
- `clr_overflow` clears `overflow`. A simultaneous drop wins, so `overflow` stays 1.
- Drain FSM states:
  - IDLE: if `!empty && !uart_busy`, set `pop`, latch `mem[rd_ptr]` into `uart_data`, and go to SEND.
  - SEND: `uart_write_enable = 1` for this cycle only. Go to ARM.
  - ARM: one cycle that ignores `uart_busy`, because `Uart` raises `busy` the cycle after `write_enable`. Go to DRAIN.
  - DRAIN: stay while `uart_busy`. When `uart_busy == 0`, go to IDLE.
- `uart_data` holds its latched value from pop until the next pop.
- `count` update: `count + push - pop`. Simultaneous push and pop leaves it unchanged.
- `flush`:
  - Sets `rd_ptr = wr_ptr` and `count = 0` next cycle. Overrides a same-cycle push (byte discarded, not counted as overflow).
  - Does not change the FSM; an in-flight byte completes.
  - A same-cycle IDLE pop is suppressed: the FSM stays IDLE.

## Timing
- Reset values:
  - `count = 0`, pointers 0, `empty = 1`, `full = 0`, `overflow = 0`.
  - FSM in IDLE, `uart_data = 8'h00`, `uart_write_enable = 0`, `tx_active = 0`.
- Reset mid-transmission returns to IDLE and empties the FIFO. `Uart` is reset by the same `rst`.
- Latency: push at cycle t into an empty FIFO with `Uart` idle. `count = 1` at t+1, pop at t+1, `uart_write_enable` high in t+2.
- Minimum spacing between launches is 3 cycles plus the `busy` duration.
- `full`, `empty`, `count`, `tx_active` are registered-state decodes and do not depend combinationally on `wr_en`.

## Structure
- Shared package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, SEND, ARM, DRAIN} uart_tx_state_t`.
  - Constants `UART_RW_ADDRESS`, `UART_STATUS_ADDRESS`, `BAUD_MAX_ADDRESS`, also used by the top-level decode.
- One sub-module, `sync_fifo` (parameterised DEPTH and WIDTH = 8):
  - Contains storage, pointers, count, push/pop/flush.
  - The drain FSM and overflow flag live in `uart_tx_fifo`.

## Test plan
- Reset, then idle 5 cycles. Expect `empty = 1`, `count = 0`, `uart_write_enable` never high, `tx_active = 0`.
- Push `8'h41` with `uart_busy` low, busy model high for 10 cycles after the launch. Expect `uart_write_enable` pulse exactly at push+2 with `uart_data = 8'h41`, then `tx_active` drops after busy falls.
- Push 16 bytes `8'h00..8'h0F` back-to-back while `uart_busy` is held high.
  - Expect `full = 1` after the 16th push.
  - A 17th push (`8'hFF`) sets `overflow` and is not transmitted.
  - Releasing busy transmits `00..0F` in order.
- With `full = 1`, push in the same cycle as an IDLE pop. Expect the push accepted, `count` stays 16, `overflow` stays 0.
- Queue 5 bytes, then assert `flush` one cycle after the first launch. Expect only the first byte transmitted, `count = 0` next cycle, and the FSM completes DRAIN normally.
- Assert `rst` while the FSM is in DRAIN with 3 bytes queued. Next cycle expect IDLE, `count = 0`, no further `uart_write_enable`.
